// File: rtl/uart_rx_deserializer_if.sv
// Serial-line and parallel-result bundle between the RX pad side and the deserializer.
// No storage; wiring only.
// No backpressure: data_valid is a single-cycle strobe with no ready.
interface uart_rx_deserializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [5:0]            Prescale;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  // Stimulus side: drives the line and frame configuration, observes results.
  modport master (
    output RX_IN, PAR_EN, PAR_TYP, Prescale,
    input  P_DATA, data_valid, par_err, stp_err
  );

  // Deserializer side.
  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, Prescale,
    output P_DATA, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// Oversampled UART receiver: start detect, 3-sample mid-bit majority, LSB-first shift, parity/stop check.
// Latency: start detect to data_valid = S*P + P/2 + 3 cycles (S = stop bit index).
// No backpressure: each good frame produces a one-cycle data_valid strobe that cannot be stalled.
module uart_rx_deserializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                   Clk,
  input  logic                   RST,
  uart_rx_deserializer_if.slave  rx_if
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]            state_q,   state_d;
  logic [5:0]            cnt_q,     cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [2:0]            smp_q,     smp_d;
  logic [DATA_WIDTH-1:0] shift_q,   shift_d;
  logic [5:0]            p_q,       p_d;
  logic                  par_en_q,  par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  done_q,    done_d;
  logic [DATA_WIDTH-1:0] data_q,    data_d;
  logic                  dv_q,      dv_d;

  logic       rx;
  logic [5:0] p_sel;
  logic [5:0] half;
  logic [5:0] pt_a, pt_b, pt_c, pt_dec, pt_last;
  logic       maj;

  assign rx = rx_if.RX_IN;

  // Unsupported oversampling ratios fall back to 8.
  always_comb begin
    case (rx_if.Prescale)
      6'd16:   p_sel = 6'd16;
      6'd32:   p_sel = 6'd32;
      default: p_sel = 6'd8;
    endcase
  end

  // Sample/decision points derive from the ratio latched for this frame.
  assign half    = {1'b0, p_q[5:1]};
  assign pt_a    = half - 6'd1;
  assign pt_b    = half;
  assign pt_c    = half + 6'd1;
  assign pt_dec  = half + 6'd2;
  assign pt_last = p_q - 6'd1;
  assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

  // Next-state logic: frame FSM, edge/bit counters, sampling and result stage.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    smp_d     = smp_q;
    shift_d   = shift_q;
    p_d       = p_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_err_d = par_err_q;
    stp_err_d = stp_err_q;
    done_d    = 1'b0;
    data_d    = data_q;
    dv_d      = 1'b0;

    // Result stage runs one cycle after the stop decision so both flags are final.
    if (done_q && !par_err_q && !stp_err_q) begin
      dv_d   = 1'b1;
      data_d = shift_q;
    end

    if (state_q != S_IDLE) begin
      if (cnt_q == pt_a) smp_d[0] = rx;
      if (cnt_q == pt_b) smp_d[1] = rx;
      if (cnt_q == pt_c) smp_d[2] = rx;
      cnt_d = (cnt_q == pt_last) ? 6'd0 : cnt_q + 6'd1;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = 6'd0;
        if (!rx) begin
          // Detection cycle is edge 0 of the start bit, so the next edge is 1.
          state_d   = S_START;
          cnt_d     = 6'd1;
          bit_cnt_d = '0;
          p_d       = p_sel;
          par_en_d  = rx_if.PAR_EN;
          par_typ_d = rx_if.PAR_TYP;
          par_err_d = 1'b0;
          stp_err_d = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == pt_dec && maj) begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
        end else if (cnt_q == pt_last) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == pt_dec) shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
        if (cnt_q == pt_last) begin
          if (bit_cnt_q == BW'(DATA_WIDTH-1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (cnt_q == pt_dec) par_err_d = maj ^ (^shift_q) ^ par_typ_q;
        if (cnt_q == pt_last) state_d = S_STOP;
      end
      S_STOP: begin
        // Return to IDLE at mid stop bit so a following start bit is never missed.
        if (cnt_q == pt_dec) begin
          stp_err_d = ~maj;
          done_d    = 1'b1;
          state_d   = S_IDLE;
          cnt_d     = 6'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // State registers with synchronous reset; a reset mid-frame drops the partial frame.
  always_ff @(posedge Clk) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      bit_cnt_q <= '0;
      smp_q     <= 3'd0;
      shift_q   <= '0;
      p_q       <= 6'd8;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= '0;
      dv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      smp_q     <= smp_d;
      shift_q   <= shift_d;
      p_q       <= p_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
      done_q    <= done_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
    end
  end

  assign rx_if.P_DATA     = data_q;
  assign rx_if.data_valid = dv_q;
  assign rx_if.par_err    = par_err_q;
  assign rx_if.stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: drives serial frames, records data_valid strobes with cycle stamps.
module tb_uart_rx_deserializer;
  logic Clk = 1'b0;
  logic RST;

  uart_rx_deserializer_if #(.DATA_WIDTH(8)) bus();

  uart_rx_deserializer #(.DATA_WIDTH(8)) dut (
    .Clk   (Clk),
    .RST   (RST),
    .rx_if (bus.slave)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc = cyc + 1;

  logic [7:0] dv_dat[$];
  int         dv_cyc[$];
  always @(negedge Clk) begin
    if (bus.data_valid === 1'b1) begin
      dv_dat.push_back(bus.P_DATA);
      dv_cyc.push_back(cyc);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  logic       st_par, st_stp;
  logic       rst_fired;
  logic [7:0] rst_dat;
  logic       rst_dv, rst_par, rst_stp;

  task automatic idle(input int n);
    bus.RX_IN = 1'b1;
    repeat (n) @(negedge Clk);
  endtask

  // One frame, every bit held P cycles. glitch_k/glitch_e flip one cycle; rst_k pulses RST and aborts.
  task automatic send_frame(input logic [7:0] dat, input int p, input bit par_en, input bit par_bit,
                            input bit stop_low, input int glitch_k, input int glitch_e,
                            input int rst_k, output int t0);
    int  nbits;
    bit  abort;
    logic val, v;
    nbits = par_en ? 11 : 10;
    abort = 1'b0;
    t0 = -1;
    for (int k = 0; k < nbits && !abort; k++) begin
      if (k == 0) val = 1'b0;
      else if (k <= 8) val = dat[k-1];
      else if (par_en && k == 9) val = par_bit;
      else val = 1'b1;
      for (int e = 0; e < p && !abort; e++) begin
        v = val;
        if (k == glitch_k && e == glitch_e) v = ~v;
        if (k == nbits - 1 && stop_low) v = (e <= p / 2 + 2) ? 1'b0 : 1'b1;
        bus.RX_IN = v;
        if (k == 0 && e == 0) t0 = cyc + 1;
        if (k == rst_k && e == 2) RST = 1'b1;
        @(negedge Clk);
        if (k == 0 && e == 0) begin
          st_par = bus.par_err;
          st_stp = bus.stp_err;
        end
        if (RST) begin
          RST       = 1'b0;
          rst_fired = 1'b1;
          rst_dat   = bus.P_DATA;
          rst_dv    = bus.data_valid;
          rst_par   = bus.par_err;
          rst_stp   = bus.stp_err;
          abort     = 1'b1;
        end
      end
    end
    bus.RX_IN = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.RX_IN = 1'b1; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.Prescale = 6'd16;
    repeat (3) @(negedge Clk);
    RST = 1'b0;
    @(negedge Clk);
    n_chk++; if (bus.P_DATA !== 8'h00) $display("FAIL reset_pdata: got %h want 00", bus.P_DATA); else n_pass++;
    n_chk++; if (bus.data_valid !== 1'b0) $display("FAIL reset_dv: got %b want 0", bus.data_valid); else n_pass++;
    n_chk++; if (bus.par_err !== 1'b0) $display("FAIL reset_par: got %b want 0", bus.par_err); else n_pass++;
    n_chk++; if (bus.stp_err !== 1'b0) $display("FAIL reset_stp: got %b want 0", bus.stp_err); else n_pass++;
  endtask

  task automatic test_8n1();
    int t0;
    dv_dat.delete(); dv_cyc.delete();
    bus.Prescale = 6'd16; bus.PAR_EN = 1'b0;
    send_frame(8'hA5, 16, 0, 0, 0, -1, -1, -1, t0);
    idle(10);
    n_chk++; if (dv_dat.size() !== 1) $display("FAIL 8n1_count: got %0d want 1", dv_dat.size()); else n_pass++;
    n_chk++; if (((dv_dat.size() > 0) ? dv_dat[0] : 8'hxx) !== 8'hA5) $display("FAIL 8n1_data: got %h want a5", (dv_dat.size() > 0) ? dv_dat[0] : 8'hxx); else n_pass++;
    n_chk++; if (((dv_cyc.size() > 0) ? dv_cyc[0] : -1) !== t0 + 155) $display("FAIL 8n1_latency: got %0d want %0d", (dv_cyc.size() > 0) ? dv_cyc[0] : -1, t0 + 155); else n_pass++;
    n_chk++; if (bus.P_DATA !== 8'hA5) $display("FAIL 8n1_pdata_hold: got %h want a5", bus.P_DATA); else n_pass++;
    n_chk++; if (bus.par_err !== 1'b0) $display("FAIL 8n1_par: got %b want 0", bus.par_err); else n_pass++;
    n_chk++; if (bus.stp_err !== 1'b0) $display("FAIL 8n1_stp: got %b want 0", bus.stp_err); else n_pass++;
  endtask

  task automatic test_8e1_parity();
    int t0a, t0b;
    dv_dat.delete(); dv_cyc.delete();
    bus.Prescale = 6'd8; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0;
    send_frame(8'h3C, 8, 1, 0, 0, -1, -1, -1, t0a);
    idle(10);
    send_frame(8'h3C, 8, 1, 1, 0, -1, -1, -1, t0b);
    idle(10);
    n_chk++; if (dv_dat.size() !== 1) $display("FAIL 8e1_count: got %0d want 1", dv_dat.size()); else n_pass++;
    n_chk++; if (((dv_dat.size() > 0) ? dv_dat[0] : 8'hxx) !== 8'h3C) $display("FAIL 8e1_data: got %h want 3c", (dv_dat.size() > 0) ? dv_dat[0] : 8'hxx); else n_pass++;
    n_chk++; if (((dv_cyc.size() > 0) ? dv_cyc[0] : -1) !== t0a + 87) $display("FAIL 8e1_latency: got %0d want %0d", (dv_cyc.size() > 0) ? dv_cyc[0] : -1, t0a + 87); else n_pass++;
    n_chk++; if (bus.par_err !== 1'b1) $display("FAIL 8e1_par_err: got %b want 1", bus.par_err); else n_pass++;
    n_chk++; if (bus.stp_err !== 1'b0) $display("FAIL 8e1_stp: got %b want 0", bus.stp_err); else n_pass++;
    n_chk++; if (bus.P_DATA !== 8'h3C) $display("FAIL 8e1_pdata_hold: got %h want 3c", bus.P_DATA); else n_pass++;
  endtask

  task automatic test_8o1_stop_err();
    int t0a, t0b;
    dv_dat.delete(); dv_cyc.delete();
    bus.Prescale = 6'd32; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b1;
    send_frame(8'h00, 32, 1, 1, 1, -1, -1, -1, t0a);
    idle(10);
    n_chk++; if (dv_dat.size() !== 0) $display("FAIL 8o1_count: got %0d want 0", dv_dat.size()); else n_pass++;
    n_chk++; if (bus.stp_err !== 1'b1) $display("FAIL 8o1_stp_err: got %b want 1", bus.stp_err); else n_pass++;
    n_chk++; if (bus.par_err !== 1'b0) $display("FAIL 8o1_par: got %b want 0", bus.par_err); else n_pass++;
    n_chk++; if (bus.P_DATA !== 8'h3C) $display("FAIL 8o1_pdata_hold: got %h want 3c", bus.P_DATA); else n_pass++;
    bus.Prescale = 6'd16; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    send_frame(8'h96, 16, 0, 0, 0, -1, -1, -1, t0b);
    idle(10);
    n_chk++; if (st_stp !== 1'b0) $display("FAIL 8o1_stp_clear_at_start: got %b want 0", st_stp); else n_pass++;
    n_chk++; if (st_par !== 1'b0) $display("FAIL 8o1_par_clear_at_start: got %b want 0", st_par); else n_pass++;
    n_chk++; if (((dv_dat.size() > 0) ? dv_dat[0] : 8'hxx) !== 8'h96) $display("FAIL 8o1_next_data: got %h want 96", (dv_dat.size() > 0) ? dv_dat[0] : 8'hxx); else n_pass++;
  endtask

  task automatic test_start_glitch();
    int t0;
    dv_dat.delete(); dv_cyc.delete();
    bus.Prescale = 6'd16; bus.PAR_EN = 1'b0;
    bus.RX_IN = 1'b0;
    repeat (3) @(negedge Clk);
    idle(20);
    n_chk++; if (dv_dat.size() !== 0) $display("FAIL glitch_no_strobe: got %0d want 0", dv_dat.size()); else n_pass++;
    n_chk++; if (bus.par_err !== 1'b0) $display("FAIL glitch_par: got %b want 0", bus.par_err); else n_pass++;
    n_chk++; if (bus.stp_err !== 1'b0) $display("FAIL glitch_stp: got %b want 0", bus.stp_err); else n_pass++;
    send_frame(8'h5A, 16, 0, 0, 0, -1, -1, -1, t0);
    idle(10);
    n_chk++; if (((dv_dat.size() > 0) ? dv_dat[0] : 8'hxx) !== 8'h5A) $display("FAIL glitch_next_data: got %h want 5a", (dv_dat.size() > 0) ? dv_dat[0] : 8'hxx); else n_pass++;
    n_chk++; if (((dv_cyc.size() > 0) ? dv_cyc[0] : -1) !== t0 + 155) $display("FAIL glitch_next_latency: got %0d want %0d", (dv_cyc.size() > 0) ? dv_cyc[0] : -1, t0 + 155); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes_v [3];
    int         t0s [3];
    bytes_v[0] = 8'h01; bytes_v[1] = 8'hFF; bytes_v[2] = 8'h80;
    dv_dat.delete(); dv_cyc.delete();
    bus.Prescale = 6'd16; bus.PAR_EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      // Middle frame: data bit 3 (frame bit 4) is flipped at its centre sample only.
      send_frame(bytes_v[i], 16, 0, 0, 0, (i == 1) ? 4 : -1, 8, -1, t0s[i]);
    end
    idle(10);
    n_chk++; if (dv_dat.size() !== 3) $display("FAIL b2b_count: got %0d want 3", dv_dat.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (((dv_dat.size() > i) ? dv_dat[i] : 8'hxx) !== bytes_v[i]) $display("FAIL b2b_data%0d: got %h want %h", i, (dv_dat.size() > i) ? dv_dat[i] : 8'hxx, bytes_v[i]); else n_pass++;
      n_chk++; if (((dv_cyc.size() > i) ? dv_cyc[i] : -1) !== t0s[i] + 155) $display("FAIL b2b_latency%0d: got %0d want %0d", i, (dv_cyc.size() > i) ? dv_cyc[i] : -1, t0s[i] + 155); else n_pass++;
    end
  endtask

  task automatic test_rst_mid_frame();
    int t0a, t0b;
    dv_dat.delete(); dv_cyc.delete();
    bus.Prescale = 6'd16; bus.PAR_EN = 1'b0;
    rst_fired = 1'b0;
    send_frame(8'hFF, 16, 0, 0, 0, -1, -1, 5, t0a);
    idle(20);
    n_chk++; if (rst_fired !== 1'b1) $display("FAIL rst_pulse_applied: got %b want 1", rst_fired); else n_pass++;
    n_chk++; if (rst_dat !== 8'h00) $display("FAIL rst_pdata: got %h want 00", rst_dat); else n_pass++;
    n_chk++; if (rst_dv !== 1'b0) $display("FAIL rst_dv: got %b want 0", rst_dv); else n_pass++;
    n_chk++; if ({rst_par, rst_stp} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {rst_par, rst_stp}); else n_pass++;
    n_chk++; if (dv_dat.size() !== 0) $display("FAIL rst_no_strobe: got %0d want 0", dv_dat.size()); else n_pass++;
    send_frame(8'hC3, 16, 0, 0, 0, -1, -1, -1, t0b);
    idle(10);
    n_chk++; if (((dv_dat.size() > 0) ? dv_dat[0] : 8'hxx) !== 8'hC3) $display("FAIL rst_next_data: got %h want c3", (dv_dat.size() > 0) ? dv_dat[0] : 8'hxx); else n_pass++;
    n_chk++; if (((dv_cyc.size() > 0) ? dv_cyc[0] : -1) !== t0b + 155) $display("FAIL rst_next_latency: got %0d want %0d", (dv_cyc.size() > 0) ? dv_cyc[0] : -1, t0b + 155); else n_pass++;
  endtask

  initial begin
    RST = 1'b1;
    bus.RX_IN = 1'b1;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    bus.Prescale = 6'd16;
    @(negedge Clk);
    test_reset();
    test_8n1();
    test_8e1_parity();
    test_8o1_stop_err();
    test_start_glitch();
    test_back_to_back();
    test_rst_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
